// File: rtl/fault_detect_sequencer.sv
// Stuck-at fault campaign sequencer: injects each fault, applies its vectors,
// compares fault-free vs faulty outputs after a settle time and counts detections.
module fault_detect_sequencer #(
   parameter int IN_W       = 3,
   parameter int OUT_W      = 6,
   parameter int FID_W      = 12,
   parameter int SETTLE     = 2,
   parameter int N_DETECT   = 1,
   parameter int EARLY_STOP = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             fault_valid,
   output logic             fault_ready,
   input  logic [FID_W-1:0] fault_id,
   input  logic             fault_last,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  logic [IN_W-1:0]  vec_data,
   input  logic             vec_last,
   output logic [IN_W-1:0]  stim,
   output logic             inject_en,
   output logic [FID_W-1:0] inject_id,
   input  logic [OUT_W-1:0] good_out,
   input  logic [OUT_W-1:0] faulty_out,
   output logic             det_valid,
   output logic [FID_W-1:0] det_fault_id,
   output logic [CNT_W-1:0] det_vec_idx,
   output logic [CNT_W-1:0] fault_cnt,
   output logic [CNT_W-1:0] detect_cnt,
   output logic             busy,
   output logic             done
);

   typedef enum logic [3:0] {
      S_IDLE, S_GET_FAULT, S_INJECT, S_GET_VEC, S_WAIT,
      S_COMPARE, S_DRAIN, S_REMOVE, S_DONE
   } state_t;

   // WAIT runs SETTLE-1 cycles, so its down-counter starts at SETTLE-2
   localparam logic [3:0]       SETTLE_LOAD = (SETTLE >= 2) ? 4'(SETTLE - 2) : 4'd0;
   localparam logic [3:0]       N_DET_M1    = 4'(N_DETECT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t           r_state;
   state_t           w_state_next;
   logic [IN_W-1:0]  r_stim;
   logic             r_inject_en;
   logic [FID_W-1:0] r_inject_id;
   logic             r_fault_last;
   logic             r_vec_last;
   logic [3:0]       r_settle_cnt;
   logic [3:0]       r_mis_cnt;
   logic             r_detected;
   logic [CNT_W-1:0] r_vec_idx;
   logic [CNT_W-1:0] r_fault_cnt;
   logic [CNT_W-1:0] r_detect_cnt;
   logic             r_det_valid;
   logic [FID_W-1:0] r_det_fault_id;
   logic [CNT_W-1:0] r_det_vec_idx;
   logic             r_busy;
   logic             r_done;

   logic w_fault_ready;
   logic w_vec_ready;
   logic w_mismatch;
   logic w_detect_now;

   assign w_mismatch   = (good_out != faulty_out);
   assign w_detect_now = (r_state == S_COMPARE) && w_mismatch && !r_detected &&
                         (r_mis_cnt == N_DET_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next  = r_state;
      w_fault_ready = 1'b0;
      w_vec_ready   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) w_state_next = S_GET_FAULT;
         end
         S_GET_FAULT: begin
            w_fault_ready = 1'b1;
            if (fault_valid) w_state_next = S_INJECT;
         end
         S_INJECT: w_state_next = S_GET_VEC;
         S_GET_VEC: begin
            w_vec_ready = 1'b1;
            if (vec_valid) w_state_next = (SETTLE == 1) ? S_COMPARE : S_WAIT;
         end
         S_WAIT: begin
            if (r_settle_cnt == 4'd0) w_state_next = S_COMPARE;
         end
         S_COMPARE: begin
            if (r_vec_last)
               w_state_next = S_REMOVE;
            else if ((r_detected || w_detect_now) && (EARLY_STOP != 0))
               w_state_next = S_DRAIN;
            else
               w_state_next = S_GET_VEC;
         end
         S_DRAIN: begin
            w_vec_ready = 1'b1;
            if (vec_valid && vec_last) w_state_next = S_REMOVE;
         end
         S_REMOVE: w_state_next = r_fault_last ? S_DONE : S_GET_FAULT;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stim         <= '0;
         r_inject_en    <= 1'b0;
         r_inject_id    <= '0;
         r_fault_last   <= 1'b0;
         r_vec_last     <= 1'b0;
         r_settle_cnt   <= '0;
         r_mis_cnt      <= '0;
         r_detected     <= 1'b0;
         r_vec_idx      <= '0;
         r_fault_cnt    <= '0;
         r_detect_cnt   <= '0;
         r_det_valid    <= 1'b0;
         r_det_fault_id <= '0;
         r_det_vec_idx  <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_det_valid <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_fault_cnt  <= '0;
                  r_detect_cnt <= '0;
                  r_mis_cnt    <= '0;
                  r_vec_idx    <= '0;
                  r_detected   <= 1'b0;
                  r_done       <= 1'b0;
                  r_busy       <= 1'b1;
               end
            end
            S_GET_FAULT: begin
               if (fault_valid) begin
                  r_inject_id  <= fault_id;
                  r_fault_last <= fault_last;
                  r_inject_en  <= 1'b1;
               end
            end
            S_GET_VEC: begin
               if (vec_valid) begin
                  r_stim       <= vec_data;
                  r_vec_last   <= vec_last;
                  r_settle_cnt <= SETTLE_LOAD;
               end
            end
            S_WAIT: begin
               if (r_settle_cnt != 4'd0) r_settle_cnt <= r_settle_cnt - 4'd1;
            end
            S_COMPARE: begin
               // Mismatches stop accumulating once the fault is declared detected
               if (w_mismatch && !r_detected) r_mis_cnt <= r_mis_cnt + 4'd1;
               if (w_detect_now) begin
                  r_detected     <= 1'b1;
                  r_det_valid    <= 1'b1;
                  r_det_fault_id <= r_inject_id;
                  r_det_vec_idx  <= r_vec_idx;
                  if (r_detect_cnt != CNT_MAX) r_detect_cnt <= r_detect_cnt + 1'b1;
               end
               if (r_vec_idx != CNT_MAX) r_vec_idx <= r_vec_idx + 1'b1;
            end
            S_REMOVE: begin
               r_inject_en <= 1'b0;
               r_mis_cnt   <= '0;
               r_vec_idx   <= '0;
               r_detected  <= 1'b0;
               if (r_fault_cnt != CNT_MAX) r_fault_cnt <= r_fault_cnt + 1'b1;
               if (r_fault_last) begin
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign fault_ready  = w_fault_ready;
   assign vec_ready    = w_vec_ready;
   assign stim         = r_stim;
   assign inject_en    = r_inject_en;
   assign inject_id    = r_inject_id;
   assign det_valid    = r_det_valid;
   assign det_fault_id = r_det_fault_id;
   assign det_vec_idx  = r_det_vec_idx;
   assign fault_cnt    = r_fault_cnt;
   assign detect_cnt   = r_detect_cnt;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule
